// File: rtl/aes_wb_pkg.sv
// Shared definitions for the AES Wishbone job sequencer: aes_top register map,
// CTRL/STATUS bit positions and the sequencer state encoding.
package aes_wb_pkg;

  localparam logic [31:0] OFF_KEY    = 32'h00;
  localparam logic [31:0] OFF_DIN    = 32'h10;
  localparam logic [31:0] OFF_CTRL   = 32'h20;
  localparam logic [31:0] OFF_STATUS = 32'h24;
  localparam logic [31:0] OFF_DOUT   = 32'h28;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_DECRYPT_BIT = 1;
  localparam int STATUS_DONE_BIT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_KEY,
    ST_WR_DIN,
    ST_WR_CTRL,
    ST_POLL,
    ST_RD_DOUT,
    ST_RESP
  } seq_state_e;

  function automatic logic [31:0] word_offset(input logic [1:0] idx);
    return {28'h0, idx, 2'b00};
  endfunction

  // Word 0 is the most significant 32 bits of a 128-bit block.
  function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_wb_sequencer_if.sv
// Wishbone B3 classic signal bundle between the sequencer's access engine and
// the tile bus.
interface aes_wb_sequencer_if;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (output adr, dat_m2s, sel, we, cyc, stb, input dat_s2m, ack, err);
  modport slave  (input adr, dat_m2s, sel, we, cyc, stb, output dat_s2m, ack, err);
endinterface

// File: rtl/aes_wb_sequencer_wb_single_access.sv
// Single Wishbone classic transaction engine with an ack timeout. done/err are
// combinational on the cycle ack/err is sampled so the caller can advance at once.
module wb_single_access #(
  parameter int ACK_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        err,
  output logic [31:0] rdat,
  aes_wb_sequencer_if.master bus
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;

  // A new access is launched only from the idle cycle, which guarantees the
  // one-cycle gap between back-to-back accesses.
  always_comb begin
    timeout = cyc_q && (cnt_q == CW'(ACK_TIMEOUT));
    done    = cyc_q && (bus.ack || bus.err || timeout);
    err     = cyc_q && (bus.err || (timeout && !bus.ack));
    rdat    = bus.dat_s2m;

    cyc_d = cyc_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    cnt_d = '0;

    if (cyc_q) begin
      if (done) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        adr_d = '0;
        dat_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (req) begin
      cyc_d = 1'b1;
      we_d  = we;
      adr_d = adr;
      dat_d = wdat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      cnt_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.cyc     = cyc_q;
  assign bus.stb     = cyc_q;
  assign bus.we      = we_q;
  assign bus.adr     = adr_q;
  assign bus.dat_m2s = dat_q;
  assign bus.sel     = {4{cyc_q}};

endmodule

// File: rtl/aes_wb_sequencer.sv
// Wishbone master that runs one AES-128 job on aes_top: key (unless cached),
// input block, CTRL, STATUS polling and output block readback.
module aes_wb_sequencer
  import aes_wb_pkg::*;
#(
  parameter logic [31:0] AES_BASE    = 32'h0000_0000,
  parameter int          POLL_MAX    = 1024,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [127:0] job_key,
  input  logic [127:0] job_data,
  input  logic         job_decrypt,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_err,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  output logic [3:0]   wbm_sel_o,
  output logic         wbm_we_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i,
  input  logic         wbm_err_i
);

  seq_state_e   state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [15:0]  poll_q, poll_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic         dec_q, dec_d;
  logic [127:0] cache_key_q, cache_key_d;
  logic         key_cached_q, key_cached_d;
  logic [127:0] res_data_q, res_data_d;
  logic         res_err_q, res_err_d;

  logic         acc_req, acc_we, acc_done, acc_err;
  logic [31:0]  acc_adr, acc_wdat, acc_rdat;
  logic         abort;

  aes_wb_sequencer_if wb ();

  wb_single_access #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_access (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .req  (acc_req),
    .we   (acc_we),
    .adr  (acc_adr),
    .wdat (acc_wdat),
    .done (acc_done),
    .err  (acc_err),
    .rdat (acc_rdat),
    .bus  (wb)
  );

  assign wbm_adr_o  = wb.adr;
  assign wbm_dat_o  = wb.dat_m2s;
  assign wbm_sel_o  = wb.sel;
  assign wbm_we_o   = wb.we;
  assign wbm_cyc_o  = wb.cyc;
  assign wbm_stb_o  = wb.stb;
  assign wb.dat_s2m = wbm_dat_i;
  assign wb.ack     = wbm_ack_i;
  assign wb.err     = wbm_err_i;

  // Each access state keeps its request up until the engine reports completion;
  // idx wraps 3 -> 0 on its own as a state finishes its fourth word.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    poll_d       = poll_q;
    key_d        = key_q;
    data_d       = data_q;
    dec_d        = dec_q;
    cache_key_d  = cache_key_q;
    key_cached_d = key_cached_q;
    res_data_d   = res_data_q;
    res_err_d    = res_err_q;
    acc_req      = 1'b0;
    acc_we       = 1'b0;
    acc_adr      = AES_BASE;
    acc_wdat     = '0;
    abort        = acc_done && acc_err;

    case (state_q)
      ST_IDLE: begin
        if (job_valid) begin
          key_d      = job_key;
          data_d     = job_data;
          dec_d      = job_decrypt;
          res_data_d = '0;
          res_err_d  = 1'b0;
          idx_d      = 2'd0;
          poll_d     = '0;
          state_d    = (key_cached_q && (job_key == cache_key_q)) ? ST_WR_DIN : ST_WR_KEY;
        end
      end
      ST_WR_KEY: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = AES_BASE + OFF_KEY + word_offset(idx_q);
        acc_wdat = block_word(key_q, idx_q);
        if (acc_done && !acc_err) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cache_key_d  = key_q;
            key_cached_d = 1'b1;
            state_d      = ST_WR_DIN;
          end
        end
      end
      ST_WR_DIN: begin
        acc_req  = 1'b1;
        acc_we   = 1'b1;
        acc_adr  = AES_BASE + OFF_DIN + word_offset(idx_q);
        acc_wdat = block_word(data_q, idx_q);
        if (acc_done && !acc_err) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_WR_CTRL;
        end
      end
      ST_WR_CTRL: begin
        acc_req                    = 1'b1;
        acc_we                     = 1'b1;
        acc_adr                    = AES_BASE + OFF_CTRL;
        acc_wdat[CTRL_START_BIT]   = 1'b1;
        acc_wdat[CTRL_DECRYPT_BIT] = dec_q;
        if (acc_done && !acc_err) state_d = ST_POLL;
      end
      ST_POLL: begin
        acc_req = 1'b1;
        acc_adr = AES_BASE + OFF_STATUS;
        if (acc_done && !acc_err) begin
          poll_d = poll_q + 16'd1;
          if (acc_rdat[STATUS_DONE_BIT]) begin
            poll_d  = '0;
            state_d = ST_RD_DOUT;
          end else if ((poll_q + 16'd1) == 16'(POLL_MAX)) begin
            abort = 1'b1;
          end
        end
      end
      ST_RD_DOUT: begin
        acc_req = 1'b1;
        acc_adr = AES_BASE + OFF_DOUT + word_offset(idx_q);
        if (acc_done && !acc_err) begin
          case (idx_q)
            2'd0:    res_data_d[127:96] = acc_rdat;
            2'd1:    res_data_d[95:64]  = acc_rdat;
            2'd2:    res_data_d[63:32]  = acc_rdat;
            default: res_data_d[31:0]   = acc_rdat;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A failed job must not leave a possibly half-written key marked as cached.
    if (abort) begin
      state_d      = ST_RESP;
      key_cached_d = 1'b0;
      res_err_d    = 1'b1;
      res_data_d   = '0;
      idx_d        = 2'd0;
      poll_d       = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      poll_q       <= '0;
      key_q        <= '0;
      data_q       <= '0;
      dec_q        <= 1'b0;
      cache_key_q  <= '0;
      key_cached_q <= 1'b0;
      res_data_q   <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      poll_q       <= poll_d;
      key_q        <= key_d;
      data_q       <= data_d;
      dec_q        <= dec_d;
      cache_key_q  <= cache_key_d;
      key_cached_q <= key_cached_d;
      res_data_q   <= res_data_d;
      res_err_q    <= res_err_d;
    end
  end

  assign job_ready = (state_q == ST_IDLE);
  assign res_valid = (state_q == ST_RESP);
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_aes_wb_sequencer.sv
// Directed bench for aes_wb_sequencer against a behavioural aes_top register
// model that answers the FIPS-197 vector pair and can inject err, stall or never finish.
module tb_aes_wb_sequencer;
  import aes_wb_pkg::*;

  localparam logic [31:0]  BASE     = 32'h4000_0100;
  localparam logic [127:0] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT       = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_ALT  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_valid, job_ready, job_decrypt;
  logic [127:0] job_key, job_data;
  logic         res_valid, res_ready, res_err;
  logic [127:0] res_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_wb_sequencer_if bus ();

  aes_wb_sequencer #(.AES_BASE(BASE), .POLL_MAX(8), .ACK_TIMEOUT(64)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .job_key     (job_key),
    .job_data    (job_data),
    .job_decrypt (job_decrypt),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_err     (res_err),
    .wbm_adr_o   (bus.adr),
    .wbm_dat_o   (bus.dat_m2s),
    .wbm_sel_o   (bus.sel),
    .wbm_we_o    (bus.we),
    .wbm_cyc_o   (bus.cyc),
    .wbm_stb_o   (bus.stb),
    .wbm_dat_i   (bus.dat_s2m),
    .wbm_ack_i   (bus.ack),
    .wbm_err_i   (bus.err)
  );

  // Slave model controls and transaction log.
  bit          withhold = 1'b0;
  bit          never_done = 1'b0;
  bit          err_en = 1'b0;
  bit          log_clr = 1'b0;
  logic [31:0] err_adr = '0;
  logic        ack_r, err_r;
  logic [127:0] din_mem, dout_blk;
  logic [31:0] ctrl_val, off;
  int          stat_since_ctrl;
  int n_writes = 0, n_key_wr = 0, n_din_wr = 0, n_ctrl_wr = 0, n_stat_rd = 0, n_dout_rd = 0;

  assign bus.ack = ack_r;
  assign bus.err = err_r;
  assign off     = bus.adr - BASE;

  always_comb begin
    if (!ctrl_val[1] && din_mem == PT) dout_blk = CT;
    else if (ctrl_val[1] && din_mem == CT) dout_blk = PT;
    else dout_blk = ~din_mem;
  end

  always_comb begin
    bus.dat_s2m = '0;
    case (off)
      OFF_STATUS:          bus.dat_s2m = {31'b0, (!never_done && stat_since_ctrl >= 2)};
      OFF_DOUT:            bus.dat_s2m = dout_blk[127:96];
      OFF_DOUT + 32'h4:    bus.dat_s2m = dout_blk[95:64];
      OFF_DOUT + 32'h8:    bus.dat_s2m = dout_blk[63:32];
      OFF_DOUT + 32'hC:    bus.dat_s2m = dout_blk[31:0];
      default:             bus.dat_s2m = '0;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      ack_r           <= 1'b0;
      err_r           <= 1'b0;
      din_mem         <= '0;
      ctrl_val        <= '0;
      stat_since_ctrl <= 0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      if (bus.cyc && bus.stb && !ack_r && !err_r && !withhold) begin
        if (err_en && bus.adr == err_adr) err_r <= 1'b1;
        else ack_r <= 1'b1;
      end
      if (bus.cyc && bus.stb && ack_r) begin
        if (bus.we) begin
          n_writes <= n_writes + 1;
          if (off < OFF_DIN) begin
            n_key_wr <= n_key_wr + 1;
          end else if (off < OFF_CTRL) begin
            n_din_wr <= n_din_wr + 1;
            case (off[3:2])
              2'd0:    din_mem[127:96] <= bus.dat_m2s;
              2'd1:    din_mem[95:64]  <= bus.dat_m2s;
              2'd2:    din_mem[63:32]  <= bus.dat_m2s;
              default: din_mem[31:0]   <= bus.dat_m2s;
            endcase
          end else if (off == OFF_CTRL) begin
            n_ctrl_wr       <= n_ctrl_wr + 1;
            ctrl_val        <= bus.dat_m2s;
            stat_since_ctrl <= 0;
          end
        end else if (off == OFF_STATUS) begin
          n_stat_rd       <= n_stat_rd + 1;
          stat_since_ctrl <= stat_since_ctrl + 1;
        end else if (off >= OFF_DOUT && off <= OFF_DOUT + 32'hC) begin
          n_dout_rd <= n_dout_rd + 1;
        end
      end
    end
    if (log_clr) begin
      n_writes  <= 0;
      n_key_wr  <= 0;
      n_din_wr  <= 0;
      n_ctrl_wr <= 0;
      n_stat_rd <= 0;
      n_dout_rd <= 0;
    end
  end

  task automatic clear_log();
    @(negedge clk);
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic start_job(input logic [127:0] k, input logic [127:0] d, input logic dec);
    @(negedge clk);
    job_key     = k;
    job_data    = d;
    job_decrypt = dec;
    job_valid   = 1'b1;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  // Latency is counted in cycles from the accept edge to the first res_valid.
  task automatic wait_result(output int lat);
    bit ok = 1'b0;
    lat = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      lat++;
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL res_valid_wait: got no res_valid required res_valid within 2000 cycles");
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.cyc !== 1'b0) begin errors++; $display("[TB] FAIL reset_cyc: got %b required 0", bus.cyc); end
    checks++; if (bus.stb !== 1'b0) begin errors++; $display("[TB] FAIL reset_stb: got %b required 0", bus.stb); end
    checks++; if (bus.adr !== 32'h0) begin errors++; $display("[TB] FAIL reset_adr: got %h required 0", bus.adr); end
    checks++; if (bus.dat_m2s !== 32'h0) begin errors++; $display("[TB] FAIL reset_dat: got %h required 0", bus.dat_m2s); end
    checks++; if ({bus.sel, bus.we} !== 5'h0) begin errors++; $display("[TB] FAIL reset_sel_we: got %h required 0", {bus.sel, bus.we}); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_job_ready: got %b required 1", job_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b required 0", res_valid); end
    checks++; if (res_data !== 128'h0) begin errors++; $display("[TB] FAIL reset_res_data: got %h required 0", res_data); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_err: got %b required 0", res_err); end
    rst = 1'b0;
  endtask

  task automatic test_fips_encrypt();
    int lat;
    clear_log();
    start_job(KEY_FIPS, PT, 1'b0);
    checks++; if (job_ready !== 1'b0) begin errors++; $display("[TB] FAIL enc_job_ready_fall: got %b required 0", job_ready); end
    wait_result(lat);
    checks++; if (res_data !== CT) begin errors++; $display("[TB] FAIL enc_data: got %h required %h", res_data, CT); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("[TB] FAIL enc_err: got %b required 0", res_err); end
    checks++; if (n_writes != 9) begin errors++; $display("[TB] FAIL enc_writes: got %0d required 9", n_writes); end
    checks++; if (n_key_wr != 4) begin errors++; $display("[TB] FAIL enc_key_writes: got %0d required 4", n_key_wr); end
    checks++; if (n_dout_rd != 4) begin errors++; $display("[TB] FAIL enc_dout_reads: got %0d required 4", n_dout_rd); end
    checks++; if (ctrl_val !== 32'h1) begin errors++; $display("[TB] FAIL enc_ctrl: got %h required 1", ctrl_val); end
    checks++; if (lat != 49) begin errors++; $display("[TB] FAIL enc_latency: got %0d required 49", lat); end
    consume();
    @(negedge clk);
    checks++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL enc_return_idle: got ready=%b valid=%b required 1 0", job_ready, res_valid); end
  endtask

  task automatic test_cached_decrypt();
    int lat;
    clear_log();
    start_job(KEY_FIPS, CT, 1'b1);
    wait_result(lat);
    checks++; if (res_data !== PT) begin errors++; $display("[TB] FAIL dec_data: got %h required %h", res_data, PT); end
    checks++; if (n_key_wr != 0) begin errors++; $display("[TB] FAIL dec_key_writes: got %0d required 0", n_key_wr); end
    checks++; if (ctrl_val !== 32'h3) begin errors++; $display("[TB] FAIL dec_ctrl: got %h required 3", ctrl_val); end
    checks++; if (n_writes != 5) begin errors++; $display("[TB] FAIL dec_writes: got %0d required 5", n_writes); end
    checks++; if (lat != 37) begin errors++; $display("[TB] FAIL dec_latency: got %0d required 37", lat); end
    consume();
  endtask

  task automatic test_bus_err();
    int lat;
    clear_log();
    err_en  = 1'b1;
    err_adr = BASE + OFF_DIN + 32'h8;
    start_job(KEY_FIPS, PT, 1'b0);
    wait_result(lat);
    checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL err_flag: got %b required 1", res_err); end
    checks++; if (res_data !== 128'h0) begin errors++; $display("[TB] FAIL err_data: got %h required 0", res_data); end
    checks++; if (n_din_wr != 2 || n_ctrl_wr != 0) begin errors++; $display("[TB] FAIL err_writes: got din=%0d ctrl=%0d required 2 0", n_din_wr, n_ctrl_wr); end
    checks++; if (lat != 10) begin errors++; $display("[TB] FAIL err_latency: got %0d required 10", lat); end
    consume();
    err_en = 1'b0;
    clear_log();
    start_job(KEY_FIPS, PT, 1'b0);
    wait_result(lat);
    checks++; if (n_key_wr != 4) begin errors++; $display("[TB] FAIL err_rekey: got %0d required 4", n_key_wr); end
    checks++; if (res_data !== CT || res_err !== 1'b0) begin errors++; $display("[TB] FAIL err_retry: got %h/%b required %h/0", res_data, res_err, CT); end
    checks++; if (lat != 49) begin errors++; $display("[TB] FAIL err_retry_latency: got %0d required 49", lat); end
    consume();
  endtask

  task automatic test_poll_timeout();
    int lat;
    clear_log();
    never_done = 1'b1;
    start_job(KEY_FIPS, PT, 1'b0);
    wait_result(lat);
    checks++; if (n_stat_rd != 8) begin errors++; $display("[TB] FAIL poll_reads: got %0d required 8", n_stat_rd); end
    checks++; if (res_err !== 1'b1) begin errors++; $display("[TB] FAIL poll_err: got %b required 1", res_err); end
    checks++; if (res_data !== 128'h0) begin errors++; $display("[TB] FAIL poll_data: got %h required 0", res_data); end
    checks++; if (n_dout_rd != 0) begin errors++; $display("[TB] FAIL poll_dout_reads: got %0d required 0", n_dout_rd); end
    checks++; if (lat != 40) begin errors++; $display("[TB] FAIL poll_latency: got %0d required 40", lat); end
    consume();
    never_done = 1'b0;
  endtask

  task automatic test_ack_timeout();
    bit found = 1'b0;
    int n = 0;
    int unstable = 0;
    int drift = 0;
    withhold = 1'b1;
    clear_log();
    start_job(KEY_ALT, PT, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.stb) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL ack_stb_start: got no stb required stb within 20 cycles"); end
    while (bus.stb && n < 200) begin
      n++;
      if (bus.adr !== BASE || bus.we !== 1'b1 || bus.dat_m2s !== 32'h2b7e1516 || bus.sel !== 4'hF) unstable++;
      @(negedge clk);
    end
    checks++; if (n != 65) begin errors++; $display("[TB] FAIL ack_stb_cycles: got %0d required 65", n); end
    checks++; if (unstable != 0) begin errors++; $display("[TB] FAIL ack_hold_stable: got %0d bad cycles required 0", unstable); end
    checks++; if (res_valid !== 1'b1 || res_err !== 1'b1) begin errors++; $display("[TB] FAIL ack_abort: got valid=%b err=%b required 1 1", res_valid, res_err); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 128'h0 || bus.cyc !== 1'b0) drift++;
    end
    checks++; if (drift != 0) begin errors++; $display("[TB] FAIL ack_resp_hold: got %0d bad cycles required 0", drift); end
    checks++; if (n_writes != 0) begin errors++; $display("[TB] FAIL ack_writes: got %0d required 0", n_writes); end
    consume();
    withhold = 1'b0;
  endtask

  task automatic test_reset_mid_poll();
    bit found = 1'b0;
    int lat;
    clear_log();
    start_job(KEY_FIPS, PT, 1'b0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.cyc && bus.adr == BASE + OFF_STATUS) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("[TB] FAIL rst_reach_poll: got no STATUS access required one within 200 cycles"); end
    checks++; if (n_key_wr != 4) begin errors++; $display("[TB] FAIL rst_first_key: got %0d required 4", n_key_wr); end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cyc !== 1'b0 || bus.stb !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_drop: got cyc=%b stb=%b required 0 0", bus.cyc, bus.stb); end
    checks++; if (job_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_job_ready: got %b required 1", job_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_res_valid: got %b required 0", res_valid); end
    clear_log();
    start_job(KEY_FIPS, PT, 1'b0);
    wait_result(lat);
    checks++; if (n_key_wr != 4) begin errors++; $display("[TB] FAIL rst_rekey: got %0d required 4", n_key_wr); end
    checks++; if (res_data !== CT || res_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_next_job: got %h/%b required %h/0", res_data, res_err, CT); end
    consume();
  endtask

  initial begin
    job_valid   = 1'b0;
    job_key     = '0;
    job_data    = '0;
    job_decrypt = 1'b0;
    res_ready   = 1'b0;
    test_reset();
    test_fips_encrypt();
    test_cached_decrypt();
    test_bus_err();
    test_poll_timeout();
    test_ack_timeout();
    test_reset_mid_poll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_wb_sequencer.md
Name: aes_wb_sequencer

Overview:
- Wishbone B3 classic master that runs one complete AES-128 job on the tile's aes_top slave through wb_bus_b3.
- Per job: writes the key (skipped when cached), writes the input block, writes CTRL, polls STATUS, then reads the output block.
- Offloads AES job sequencing from picorv32_wb. Occupies one master slot on the tile bus.

Parameters:
- AES_BASE, 32'h0000_0000, byte base address of the aes_top register window.
- POLL_MAX, 1024, maximum STATUS reads before the job aborts (range 1..65535).
- ACK_TIMEOUT, 64, cycles allowed for ack/err on any single access before abort.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset: synchronous, active-high.
- job_valid  in  1  job request.
- job_ready  out  1  sequencer can accept a job.
- job_key  in  128  AES key; word0 = [127:96].
- job_data  in  128  input block; same word order as job_key.
- job_decrypt  in  1  1 = decrypt.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  128  output block.
- res_err  out  1  job aborted (bus err, ack timeout or poll timeout).
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte select; always 4'hF during an access.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  bus error.

Behaviour:
- AES register map (byte offsets from AES_BASE):
  - KEY0..3 at 0x00–0x0C.
  - DIN0..3 at 0x10–0x1C.
  - CTRL at 0x20: bit0 start, bit1 decrypt.
  - STATUS at 0x24: bit0 done.
  - DOUT0..3 at 0x28–0x34.
- Reset values: all wbm_* outputs 0; job_ready 1; res_valid 0; res_data 0; res_err 0; key_cached 0; FSM IDLE.
- FSM states: IDLE, WR_KEY, WR_DIN, WR_CTRL, POLL, RD_DOUT, RESP.
- IDLE:
  - job_ready = 1.
  - On job_valid: latch key, data and decrypt; job_ready falls next cycle.
  - Go to WR_KEY, or to WR_DIN when key_cached = 1 and the latched key equals the cached key.
- Access protocol:
  - cyc, stb, adr, we and dat are registered and asserted the cycle after the state is entered (or after the previous access completes).
  - They are held stable until ack or err is sampled high.
  - cyc and stb are 0 for exactly one cycle between consecutive accesses.
  - Minimum cost is 3 cycles per access.
- Word counter idx (2 bits) runs 0..3 in WR_KEY, WR_DIN and RD_DOUT; it wraps to 0 on leaving the state.
  - Address = base offset + 4·idx.
  - Word idx = bits [127-32·idx -: 32].
- WR_KEY complete: cache the key; key_cached = 1.
- WR_CTRL: writes {30'b0, decrypt, 1'b1}.
- POLL:
  - Reads STATUS; the poll counter increments per completed read.
  - done = 1 → RD_DOUT.
  - Counter reaches POLL_MAX with done = 0 → abort.
- RD_DOUT: captures each read word into res_data at its slot.
- RESP:
  - res_valid = 1; res_data and res_err held stable until res_ready.
  - Same-cycle res_valid & res_ready → IDLE next cycle; job_ready = 1 that same next cycle.
- Ack timeout: a counter runs while stb = 1 and clears on ack or err; reaching ACK_TIMEOUT means abort.
- Abort (wbm_err_i, ack timeout or poll timeout):
  - Drop cyc and stb next cycle.
  - key_cached = 0.
  - res_err = 1, res_data = 0.
  - Go to RESP.
- Simultaneous ack and err: treated as err.
- job_valid while busy: ignored (job_ready = 0); the request must be held by the requester.
- wb_rst_i mid-access: cyc and stb drop on the next edge; all state returns to reset values; key_cached = 0.

Decomposition:
- Shared package aes_wb_pkg holds:
  - Register offset constants (KEY, DIN, CTRL, STATUS, DOUT).
  - CTRL/STATUS bit positions.
  - FSM state enum.
- One sub-module, wb_single_access: a single Wishbone classic transaction engine.
  - Inputs: req, we, adr, wdat.
  - Outputs: done, err, rdat.
  - Contains the ack-timeout counter.

Test Plan:
- FIPS-197 encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff → res_data 69c4e0d86a7b0430d8cdb78070b4c55a, res_err 0; exactly 9 writes and 4 DOUT reads observed.
- Same key, decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a → res_data 00112233445566778899aabbccddeeff; no KEY writes; CTRL written 0x3.
- Slave model asserts err on the DIN2 write → res_err 1, res_data 0; next job with the same key rewrites all 4 KEY words.
- STATUS never reaches done, POLL_MAX=8 → exactly 8 STATUS reads, then res_err 1.
- Slave withholds ack, ACK_TIMEOUT=64 → stb drops 65 cycles after assertion, res_err 1; res_ready held low for 10 cycles → res_valid and res_data stable throughout.
- wb_rst_i asserted for 1 cycle during POLL → next cycle cyc=stb=0, job_ready=1, res_valid=0; following job writes the key again.
